// File: rtl/approx_mult_pkg.sv
// Shared constants and helpers for the pipelined digit-wise approximate multiplier.
// Used by approx_mult_pipe and its 4x4 sub-multiplier lm4x4_cfg.
package approx_mult_pkg;

  localparam int SUB_W  = 4;
  localparam int PROD_W = 2 * SUB_W;

  // Flat position of the (A digit i, B digit j) pair in the mode mask and product array.
  function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j,
                                           input int unsigned d);
    return i * d + j;
  endfunction

  function automatic logic [PROD_W-1:0] approx4x4(input logic [SUB_W-1:0] a4,
                                                  input logic [SUB_W-1:0] b4,
                                                  input logic             approx,
                                                  input int unsigned      trunc);
    logic [PROD_W-1:0] p;
    logic [PROD_W-1:0] keep_mask;
    p         = {{SUB_W{1'b0}}, a4} * {{SUB_W{1'b0}}, b4};
    keep_mask = {PROD_W{1'b1}} << trunc;
    return approx ? (p & keep_mask) : p;
  endfunction

endpackage

// File: rtl/approx_mult_pipe_lm4x4_cfg.sv
// Combinational 4x4 unsigned multiplier; when approx_i is set the low TRUNC
// bits of the 8-bit product are forced to zero.
module lm4x4_cfg
  import approx_mult_pkg::*;
#(
  parameter int unsigned TRUNC = 2
) (
  input  logic [SUB_W-1:0]  a_i,
  input  logic [SUB_W-1:0]  b_i,
  input  logic              approx_i,
  output logic [PROD_W-1:0] p_o
);

  assign p_o = approx4x4(a_i, b_i, approx_i, TRUNC);

endmodule

// File: rtl/approx_mult_pipe.sv
// Three-stage approximate multiplier with valid/ready flow control.
// Optional error statistics are built when APPROX_MULT_ERR_STATS_EN is defined.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC = 2
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [WIDTH-1:0]                           in_a,
  input  logic [WIDTH-1:0]                           in_b,
  input  logic [(WIDTH/SUB_W)*(WIDTH/SUB_W)-1:0]     in_mode,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [2*WIDTH-1:0]                         out_r,
  output logic [31:0]                                err_cnt
);

  localparam int D  = WIDTH / SUB_W;
  localparam int NP = D * D;
  localparam int RW = 2 * WIDTH;

  logic adv;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [NP-1:0]    s1_mode_q;

  logic                          s2_valid_q;
  logic [NP-1:0][PROD_W-1:0]     prod_d;
  logic [NP-1:0][PROD_W-1:0]     s2_prod_q;

  logic [NP-1:0][RW-1:0]         term;
  logic [NP:0][RW-1:0]           acc;
  logic [RW-1:0]                 sum_d;

  logic          out_valid_q;
  logic [RW-1:0] out_r_q;

  // NOTE: in_ready is combinational from the output register and out_ready so a
  // full pipeline can accept a new beat in the same cycle the consumer drains one.
  assign adv      = !(out_valid_q && !out_ready);
  assign in_ready = adv;

  // Stage 1: operand and mode capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q    <= in_a;
        s1_b_q    <= in_b;
        s1_mode_q <= in_mode;
      end
    end
  end

  for (genvar gi = 0; gi < D; gi++) begin : g_row
    for (genvar gj = 0; gj < D; gj++) begin : g_col
      lm4x4_cfg #(
        .TRUNC (TRUNC)
      ) u_lm4x4 (
        .a_i      (s1_a_q[gi*SUB_W +: SUB_W]),
        .b_i      (s1_b_q[gj*SUB_W +: SUB_W]),
        .approx_i (s1_mode_q[pair_idx(gi, gj, D)]),
        .p_o      (prod_d[pair_idx(gi, gj, D)])
      );

      assign term[pair_idx(gi, gj, D)] =
        RW'(s2_prod_q[pair_idx(gi, gj, D)]) << (SUB_W * (gi + gj));
    end
  end

  // Stage 2: sub-product capture. Data registers load only with a valid beat,
  // so an idle stage never disturbs the held output value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_prod_q  <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_prod_q <= prod_d;
      end
    end
  end

  // Shifted sub-products summed at full result width; the top term never overflows.
  assign acc[0] = '0;
  for (genvar gk = 0; gk < NP; gk++) begin : g_sum
    assign acc[gk+1] = acc[gk] + term[gk];
  end
  assign sum_d = acc[NP];

  // Stage 3: output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
    end else if (adv) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_r_q <= sum_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;

`ifdef APPROX_MULT_ERR_STATS_EN
  logic [RW-1:0] s1_exact_q;
  logic [RW-1:0] s2_exact_q;
  logic [RW-1:0] s3_exact_q;
  logic [31:0]   err_cnt_q;

  // Exact product shadows the approximate datapath with identical stage enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_exact_q <= '0;
      s2_exact_q <= '0;
      s3_exact_q <= '0;
    end else if (adv) begin
      if (in_valid) begin
        s1_exact_q <= RW'(in_a) * RW'(in_b);
      end
      if (s1_valid_q) begin
        s2_exact_q <= s1_exact_q;
      end
      if (s2_valid_q) begin
        s3_exact_q <= s2_exact_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (out_valid_q && out_ready && (out_r_q != s3_exact_q) &&
                 (err_cnt_q != 32'hFFFF_FFFF)) begin
      err_cnt_q <= err_cnt_q + 32'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed self-checking bench for approx_mult_pipe (8-bit TRUNC=2 and 16-bit TRUNC=0 builds).
module tb_approx_mult_pipe;

`ifdef APPROX_MULT_ERR_STATS_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [3:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_r;
  logic [31:0] err_cnt;

  logic        in_valid16;
  logic        in_ready16;
  logic [15:0] in_a16;
  logic [15:0] in_b16;
  logic [15:0] in_mode16;
  logic        out_valid16;
  logic        out_ready16;
  logic [31:0] out_r16;
  logic [31:0] err_cnt16;

  int n_tests;
  int n_fail;

  logic [7:0]  va [10];
  logic [7:0]  vb [10];
  logic [3:0]  vm [10];
  logic [15:0] ve [10];

  always #5 clk = ~clk;

  approx_mult_pipe #(.WIDTH(8), .TRUNC(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .err_cnt   (err_cnt)
  );

  approx_mult_pipe #(.WIDTH(16), .TRUNC(0)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .in_a      (in_a16),
    .in_b      (in_b16),
    .in_mode   (in_mode16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .out_r     (out_r16),
    .err_cnt   (err_cnt16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] m);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_mode  = m;
  endtask

  // Operand lines carry junk while idle; they must be ignored.
  task automatic idle();
    in_valid = 1'b0;
    in_a     = 8'h5A;
    in_b     = 8'hA5;
    in_mode  = 4'hF;
  endtask

  task automatic single(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] m, input logic [15:0] exp);
    drive(a, b, m);
    tick();
    idle();
    tick();
    check({tag, "_lat1"}, 64'(out_valid), 64'd0);
    tick();
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check(tag, 64'(out_r), 64'(exp));
    tick();
  endtask

  initial begin
    int  ptr;
    int  got;
    logic in_fire;
    logic out_fire;

    n_tests = 0;
    n_fail  = 0;
    va = '{8'h00, 8'h01, 8'h10, 8'h12, 8'hFF, 8'hFF, 8'h80, 8'h0F, 8'hAB, 8'hAB};
    vb = '{8'h00, 8'h01, 8'h10, 8'h34, 8'h01, 8'h01, 8'h80, 8'hF0, 8'hCD, 8'hCD};
    vm = '{4'h0,  4'hF,  4'h0,  4'h0,  4'h0,  4'hF,  4'h0,  4'h2,  4'h0,  4'hF};
    ve = '{16'h0000, 16'h0000, 16'h0100, 16'h03A8, 16'h00FF,
           16'h00CC, 16'h4000, 16'h0E00, 16'h88EF, 16'h88CC};

    rst_n       = 1'b0;
    idle();
    out_ready   = 1'b1;
    in_valid16  = 1'b0;
    in_a16      = '0;
    in_b16      = '0;
    in_mode16   = '0;
    out_ready16 = 1'b1;

    repeat (2) @(posedge clk);
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_r", 64'(out_r), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // All-exact FF x FF with per-edge latency checks.
    drive(8'hFF, 8'hFF, 4'h0);
    tick();
    idle();
    check("exact_lat0", 64'(out_valid), 64'd0);
    tick();
    check("exact_lat1", 64'(out_valid), 64'd0);
    tick();
    check("exact_valid", 64'(out_valid), 64'd1);
    check("exact_ffxff", 64'(out_r), 64'h0000_FE01);
    tick();
    check("exact_drained", 64'(out_valid), 64'd0);
    check("exact_out_r_held", 64'(out_r), 64'h0000_FE01);
    check("exact_err_cnt", 64'(err_cnt), 64'd0);

    single("approx_all_ffxff", 8'hFF, 8'hFF, 4'hF, 16'hFCE0);
    check("approx_all_err_cnt", 64'(err_cnt), ERR_ON ? 64'd1 : 64'd0);

    // Mode bit i*D+j selects A digit i x B digit j.
    single("mode_p00", 8'h03, 8'h07, 4'b0001, 16'h0014);
    single("mode_p01", 8'h03, 8'h70, 4'b0010, 16'h0140);
    single("mode_p01_off_p10", 8'h30, 8'h07, 4'b0010, 16'h0150);
    single("mode_p10", 8'h30, 8'h07, 4'b0100, 16'h0140);
    single("mode_p11", 8'h30, 8'h70, 4'b1000, 16'h1400);

    // Back-to-back stream, one result per clock.
    for (int n = 0; n < 12; n++) begin
      if (n < 10) drive(va[n], vb[n], vm[n]);
      else        idle();
      tick();
      if (n >= 2) begin
        check($sformatf("b2b_valid_%0d", n - 2), 64'(out_valid), 64'd1);
        check($sformatf("b2b_data_%0d", n - 2), 64'(out_r), 64'(ve[n-2]));
      end
    end
    idle();
    tick();
    check("b2b_drained", 64'(out_valid), 64'd0);

    // Consumer stalls for 5 cycles while the producer keeps offering beats.
    ptr = 0;
    got = 0;
    for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
      out_ready = (cyc >= 5);
      if (ptr < 5) drive(va[ptr+3], vb[ptr+3], vm[ptr+3]);
      else         idle();
      #1;
      if (cyc == 3 || cyc == 4) begin
        check($sformatf("stall_in_ready_c%0d", cyc), 64'(in_ready), 64'd0);
        check($sformatf("stall_valid_c%0d", cyc), 64'(out_valid), 64'd1);
        check($sformatf("stall_hold_c%0d", cyc), 64'(out_r), 64'(ve[3]));
      end
      if (cyc == 4) check("stall_buffered", 64'(ptr), 64'd3);
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        check($sformatf("stall_data_%0d", got), 64'(out_r), 64'(ve[3+got]));
        got++;
      end
      tick();
      if (in_fire) ptr++;
    end
    idle();
    out_ready = 1'b1;
    check("stall_outputs", 64'(got), 64'd5);
    check("stall_inputs", 64'(ptr), 64'd5);
    tick();
    tick();
    check("stall_no_dup", 64'(out_valid), 64'd0);

    // Asynchronous reset in the middle of a full stream.
    drive(8'hFF, 8'hFF, 4'h0);
    tick();
    tick();
    tick();
    check("midrst_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_r", 64'(out_r), 64'd0);
    check("midrst_err_cnt", 64'(err_cnt), 64'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("midrst_flushed", 64'(out_valid), 64'd0);
    single("midrst_first", 8'hAB, 8'hCD, 4'hF, 16'h88CC);
    check("midrst_no_replay", 64'(out_valid), 64'd0);

    // 16-bit build with TRUNC=0: approximate equals exact.
    check("w16_in_ready", 64'(in_ready16), 64'd1);
    in_valid16 = 1'b1;
    in_a16     = 16'hFFFF;
    in_b16     = 16'hFFFF;
    in_mode16  = 16'hFFFF;
    tick();
    in_a16     = 16'h1234;
    in_b16     = 16'h5678;
    tick();
    in_valid16 = 1'b0;
    check("w16_lat1", 64'(out_valid16), 64'd0);
    tick();
    check("w16_valid", 64'(out_valid16), 64'd1);
    check("w16_ffff", 64'(out_r16), 64'hFFFE_0001);
    tick();
    check("w16_1234x5678", 64'(out_r16), 64'h0626_0060);
    check("w16_err_cnt", 64'(err_cnt16), 64'd0);
    tick();
    check("w16_drained", 64'(out_valid16), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_mult_pipe.md
Name: approx_mult_pipe

Overview:
- Parametrised, pipelined successor to the fixed 8x8 four-quadrant approximate multiplier.
- Splits the WIDTH-bit unsigned operands into 4-bit digits and forms every digit-pair product with a 4x4 sub-multiplier.
- Each sub-product can be exact or approximate, selected per transaction by a mode mask. The shifted sub-products are summed into a 2*WIDTH-bit result.
- Sits between operand producers and accumulator/datapath consumers, using valid/ready flow control on both sides.

Parameters:
- WIDTH, 8, operand width; must be a multiple of 4, range 8..32. D = WIDTH/4 digits.
- TRUNC, 2, number of low bits forced to 0 in an approximate 4x4 sub-product; range 0..7.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_a  in  WIDTH  unsigned operand A.
- in_b  in  WIDTH  unsigned operand B.
- in_mode  in  D*D  approximation mask; bit i*D+j=1 makes sub-product A digit i x B digit j approximate.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_r  out  2*WIDTH  product.
- err_cnt  out  32  mismatch counter (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): all pipeline valid bits 0, out_valid=0, out_r=0, err_cnt=0, all stage data registers 0. Reset mid-operation discards in-flight beats; nothing is replayed.
- Sub-product: p_ij = a_i*b_j (8 bits). If in_mode[i*D+j]=1, the low TRUNC bits of p_ij are zeroed. TRUNC=0 makes the approximate and exact products identical.
- Result: out_r = sum over i,j of p_ij << 4*(i+j). The sum is computed at full 2*WIDTH width with no overflow: the all-exact result equals a*b.
- Pipeline: three register stages.
  - S1: registers a, b and mode.
  - S2: registers all D*D sub-products.
  - S3: registers the sum, which is the output register.
- Advance enable: adv = !(out_valid && !out_ready). All stages move together when adv=1. Stages hold, including valid bits, when adv=0.
- in_ready = adv, combinational from out_valid/out_ready. A beat is accepted on a clock edge with in_valid && in_ready.
- Latency: a beat accepted at edge k appears on out_r/out_valid after edge k+2, with no stall. Throughput is 1 beat/clock with out_ready held high.
- Bubbles are not collapsed: gaps in input stay as gaps in output.
- Output hold: while out_valid=1 and out_ready=0, out_r and out_valid are stable and in_ready=0.
- Simultaneous accept and output handshake in one cycle is legal and loses no data.
- in_a, in_b and in_mode are ignored when in_valid=0. An invalid stage's data is don't-care internally but must not affect out_r while out_valid=0; out_r keeps its last value.

Optional Feature:
- Macro APPROX_MULT_ERR_STATS_EN.
- Defined:
  - S1 also carries the exact product a*b through the pipeline.
  - On each output handshake (out_valid && out_ready), err_cnt increments by 1 if out_r != exact.
  - err_cnt saturates at 32'hFFFF_FFFF and is cleared only by reset.
- Undefined: the exact-product pipeline and counter are not built, and err_cnt is tied to 0.

Decomposition:
- Package approx_mult_pkg:
  - SUB_W=4 constant.
  - Function computing the D*D index i*D+j.
  - Function approx4x4(a4, b4, approx, trunc) returning the 8-bit sub-product.
- One sub-module, lm4x4_cfg: combinational 4x4 multiplier with an approx enable and a TRUNC parameter. The block instantiates D*D copies in a generate loop feeding S2.

Test Plan:
- WIDTH=8, TRUNC=2, a=8'hFF, b=8'hFF, mode=4'h0 -> out_r=16'hFE01 two edges after accept; err_cnt stays 0 (feature on).
- Same operands, mode=4'hF -> out_r=16'hFCE0 (each 225 becomes 224); err_cnt=1 with feature on, 0 with feature off.
- mode=4'b0001 (only digit pair 0,0 approximate), a=8'h03, b=8'h07 -> p00=21 becomes 20, out_r=16'h0014.
- Back-to-back 10 random beats with out_ready=1 -> 10 outputs in order, 1 per clock, each equal to the reference model.
- out_ready held 0 for 5 cycles with continuous in_valid -> exactly 3 beats buffered, in_ready=0, out_r stable. After release, all beats emerge in order with none lost or duplicated.
- rst_n pulsed low asynchronously mid-stream -> out_valid=0, out_r=0 and err_cnt=0 immediately. After release, the first new beat emerges with normal latency.
- WIDTH=16, TRUNC=0, a=16'hFFFF, b=16'hFFFF, mode=all ones -> out_r=32'hFFFE_0001 (TRUNC=0 makes approximate equal exact).
